onchip_ram_dp_pipelined: RTL

- Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports, s1 (port A) and s2 (port B). Successor to the fixed 1024x32 single-port, unregistered-output memory.
- Adds configurable width and depth, a selectable 1- or 2-cycle pipelined read with readdatavalid, and per-byte writes on both ports.
- Adds deterministic same-address collision handling with a sticky collision flag, and clock-enable stall via waitrequest.
- Sits on the Nios system interconnect as program/data memory shared between the CPU and a DMA-style master.

---
 rtl/onchip_ram_dp_pipelined.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/onchip_ram_dp_pipelined.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports (A = s1, B = s2).
// Reads are registered (latency 1 or 2, with readdatavalid), writes are per-byte,
// read-during-write always returns the old word, and a same-address write/write
// collision keeps port A's data and raises a sticky flag.
//
// Handshake: a port's command is taken on a rising edge when chipselect=1 and
// waitrequest=0 (waitrequest is simply ~clken). Write beats read when both are
// requested. readdata is meaningful only while readdatavalid=1. A valid beat held
// through a clken=0 stall is the same beat and retires on the next enabled edge.
module onchip_ram_dp_pipelined #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 10,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "onchip_ram_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic                    a_chipselect,
  input  logic                    a_read,
  input  logic                    a_write,
  input  logic [DATA_WIDTH/8-1:0] a_byteenable,
  input  logic [DATA_WIDTH-1:0]   a_writedata,
  output logic [DATA_WIDTH-1:0]   a_readdata,
  output logic                    a_readdatavalid,
  output logic                    a_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   b_address,
  input  logic                    b_chipselect,
  input  logic                    b_read,
  input  logic                    b_write,
  input  logic [DATA_WIDTH/8-1:0] b_byteenable,
  input  logic [DATA_WIDTH-1:0]   b_writedata,
  output logic [DATA_WIDTH-1:0]   b_readdata,
  output logic                    b_readdatavalid,
  output logic                    b_waitrequest,
  output logic                    collision,
  input  logic                    collision_clr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Index 0 is port A, index 1 is port B.
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic                  cs    [2];
  logic                  rd    [2];
  logic                  wr    [2];
  logic [NB-1:0]         be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];

  assign addr[0]  = a_address;    assign addr[1]  = b_address;
  assign cs[0]    = a_chipselect; assign cs[1]    = b_chipselect;
  assign rd[0]    = a_read;       assign rd[1]    = b_read;
  assign wr[0]    = a_write;      assign wr[1]    = b_write;
  assign be[0]    = a_byteenable; assign be[1]    = b_byteenable;
  assign wdata[0] = a_writedata;  assign wdata[1] = b_writedata;

  assign a_waitrequest = ~clken;
  assign b_waitrequest = ~clken;

  logic acc_wr [2];
  logic acc_rd [2];
  logic col_hit;

  // Command acceptance; a write suppresses a simultaneous read on the same port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc_wr[p] = clken & cs[p] & wr[p];
      acc_rd[p] = clken & cs[p] & rd[p] & ~wr[p];
    end
    col_hit = acc_wr[0] & acc_wr[1] & (addr[0] == addr[1]);
  end

  // Accepted writes sit in a one-entry buffer per port and reach the array on
  // the following edge. Reads sample the array without them and patch the
  // buffered lanes back in, so old/new data never depends on the RAM primitive.
  logic                  wv_q    [2];
  logic                  wv_d    [2];
  logic [ADDR_WIDTH-1:0] waddr_q [2];
  logic [ADDR_WIDTH-1:0] waddr_d [2];
  logic [NB-1:0]         wbe_q   [2];
  logic [NB-1:0]         wbe_d   [2];
  logic [DATA_WIDTH-1:0] wdat_q  [2];
  logic [DATA_WIDTH-1:0] wdat_d  [2];

  // Load the write buffers; a colliding port-B write is dropped in full.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wv_d[p]    = acc_wr[p] & ~((p == 1) & col_hit);
      waddr_d[p] = wv_d[p] ? addr[p]  : waddr_q[p];
      wbe_d[p]   = wv_d[p] ? be[p]    : wbe_q[p];
      wdat_d[p]  = wv_d[p] ? wdata[p] : wdat_q[p];
    end
  end

  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Commit buffered writes lane by lane; buffered A/B entries never share an address.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NB; i++)
        if (wv_q[p] && wbe_q[p][i])
          mem[waddr_q[p]][i*8 +: 8] <= wdat_q[p][i*8 +: 8];
  end

  // First read stage: raw array word plus the lanes a pending write overrides.
  logic                  v1_q   [2];
  logic                  v1_d   [2];
  logic [DATA_WIDTH-1:0] rram_q [2];
  logic [DATA_WIDTH-1:0] rram_d [2];
  logic [NB-1:0]         bbe_q  [2];
  logic [NB-1:0]         bbe_d  [2];
  logic [DATA_WIDTH-1:0] bdat_q [2];
  logic [DATA_WIDTH-1:0] bdat_d [2];
  logic [DATA_WIDTH-1:0] s1_word [2];

  // Sample the array on an accepted read and compare against the write buffers.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      v1_d[p]   = clken ? acc_rd[p] : v1_q[p];
      rram_d[p] = rram_q[p];
      bbe_d[p]  = bbe_q[p];
      bdat_d[p] = bdat_q[p];
      if (acc_rd[p]) begin
        rram_d[p] = mem[addr[p]];
        bbe_d[p]  = '0;
        bdat_d[p] = '0;
        for (int q = 0; q < 2; q++) begin
          if (wv_q[q] && (waddr_q[q] == addr[p])) begin
            bbe_d[p] = bbe_d[p] | wbe_q[q];
            for (int i = 0; i < NB; i++)
              if (wbe_q[q][i]) bdat_d[p][i*8 +: 8] = wdat_q[q][i*8 +: 8];
          end
        end
      end
    end
  end

  // Merge the bypass lanes over the array word; holds while no read is taken.
  always_comb begin
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NB; i++)
        s1_word[p][i*8 +: 8] = bbe_q[p][i] ? bdat_q[p][i*8 +: 8] : rram_q[p][i*8 +: 8];
  end

  logic col_q, col_d;

  // Sticky collision flag; a new collision outranks a clear in the same cycle.
  always_comb col_d = col_hit | (col_q & ~collision_clr);

  // State registers for the write buffers, first read stage and collision flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        wv_q[p]    <= 1'b0;
        waddr_q[p] <= '0;
        wbe_q[p]   <= '0;
        wdat_q[p]  <= '0;
        v1_q[p]    <= 1'b0;
        rram_q[p]  <= '0;
        bbe_q[p]   <= '0;
        bdat_q[p]  <= '0;
      end
      col_q <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        wv_q[p]    <= wv_d[p];
        waddr_q[p] <= waddr_d[p];
        wbe_q[p]   <= wbe_d[p];
        wdat_q[p]  <= wdat_d[p];
        v1_q[p]    <= v1_d[p];
        rram_q[p]  <= rram_d[p];
        bbe_q[p]   <= bbe_d[p];
        bdat_q[p]  <= bdat_d[p];
      end
      col_q <= col_d;
    end
  end

  logic [DATA_WIDTH-1:0] rdata  [2];
  logic                  rvalid [2];

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2_q [2];
    logic                  v2_d [2];
    logic [DATA_WIDTH-1:0] s2_q [2];
    logic [DATA_WIDTH-1:0] s2_d [2];

    // Extra output stage; advances only on enabled edges and keeps its last beat.
    always_comb begin
      for (int p = 0; p < 2; p++) begin
        v2_d[p] = clken ? v1_q[p] : v2_q[p];
        s2_d[p] = (clken & v1_q[p]) ? s1_word[p] : s2_q[p];
      end
    end

    // Second-stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int p = 0; p < 2; p++) begin
          v2_q[p] <= 1'b0;
          s2_q[p] <= '0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          v2_q[p] <= v2_d[p];
          s2_q[p] <= s2_d[p];
        end
      end
    end

    // Present the second stage on the ports.
    always_comb begin
      for (int p = 0; p < 2; p++) begin
        rdata[p]  = s2_q[p];
        rvalid[p] = v2_q[p];
      end
    end
  end else begin : g_lat1
    // Present the first stage on the ports.
    always_comb begin
      for (int p = 0; p < 2; p++) begin
        rdata[p]  = s1_word[p];
        rvalid[p] = v1_q[p];
      end
    end
  end

  assign a_readdata      = rdata[0];
  assign a_readdatavalid = rvalid[0];
  assign b_readdata      = rdata[1];
  assign b_readdatavalid = rvalid[1];
  assign collision       = col_q;

endmodule
